mem_fifo_loader: RTL and testbench
==================================

MEM_FIFO_LOADER -- requirements
Module: mem_fifo_loader

Interface
REQ-001 Parameters SHALL be DATA_WIDTH, default 8, the FIFO element width in bits.
REQ-002 Parameters SHALL include NUM_ROWS, default 8, the number of A rows and A FIFOs.
REQ-003 Parameters SHALL include ROW_BYTES, default 8, the number of elements per 64-bit memory row.
REQ-004 Port clk SHALL be an input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 Port rst_n SHALL be an input, 1 bit, the asynchronous active-low reset.
REQ-006 Port start SHALL be an input, 1 bit, a one-cycle load request.
REQ-007 Port busy SHALL be an output, 1 bit, high while a load is in progress.
REQ-008 Port done SHALL be an output, 1 bit, a level that is high after all 9 rows have been delivered.
REQ-009 Port mem_address SHALL be an output, 32 bits, the row address to mem_wrapper.
REQ-010 Port mem_read SHALL be an output, 1 bit, the read request.
REQ-011 Port mem_readdata SHALL be an input, 64 bits, one row.
REQ-012 Port mem_readdatavalid SHALL be an input, 1 bit, qualifying mem_readdata.
REQ-013 Port mem_waitrequest SHALL be an input, 1 bit; while high, the request is not accepted.
REQ-014 Port a_wren SHALL be an output, NUM_ROWS bits, the per-A-FIFO write strobes.
REQ-015 Port b_wren SHALL be an output, 1 bit, the B FIFO write strobe.
REQ-016 Port wr_data SHALL be an output, DATA_WIDTH bits, shared write data for all FIFOs.
REQ-017 Port a_full SHALL be an input, NUM_ROWS bits, the A FIFO full flags.
REQ-018 Port b_full SHALL be an input, 1 bit, the B FIFO full flag.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, SHIFT, DONE.
REQ-020 In IDLE or DONE, start=1 SHALL clear row to 0, clear done, and move to REQ; start SHALL be ignored in all other states.
REQ-021 In REQ, mem_read SHALL be 1 and mem_address SHALL equal zero-extended row; both SHALL be held stable while mem_waitrequest=1.
REQ-022 A read SHALL be accepted on the cycle where mem_read=1 and mem_waitrequest=0; the FSM SHALL then go to WAIT, and mem_read SHALL be 0 outside REQ.
REQ-023 If mem_readdatavalid=1 in the accept cycle, the FSM SHALL capture the data and go directly to SHIFT, skipping WAIT.
REQ-024 In WAIT, mem_readdatavalid=1 SHALL load mem_readdata into a 64-bit shift register, clear byte_cnt, and move to SHIFT.
REQ-025 mem_readdatavalid SHALL be ignored in IDLE, SHIFT, and DONE.
REQ-026 In SHIFT, the target FIFO SHALL be B when row=0 and A[row-1] when row is 1..8.
REQ-027 Element order SHALL be byte k = mem_readdata[8k+7:8k], pushed k=0 first.
REQ-028 In SHIFT with the target not full, exactly one strobe (b_wren or a_wren[row-1]) SHALL be 1, wr_data SHALL equal the current low byte, the register SHALL shift right 8, and byte_cnt SHALL increment.
REQ-029 In SHIFT with the target full, all strobes SHALL be 0 and the register and counters SHALL hold; the FSM SHALL stall indefinitely.
REQ-030 After the 8th write of a row: row<8 SHALL increment row and go to REQ; row=8 SHALL go to DONE.
REQ-031 At most one write strobe SHALL be high in any cycle; a_wren and b_wren SHALL never be high outside SHIFT.
REQ-032 busy SHALL be 1 exactly in REQ, WAIT, and SHIFT; done SHALL be 1 exactly in DONE.
REQ-033 A load with no stalls SHALL take 9*(1 + L + 8) cycles, where L is the memory readdatavalid latency in cycles (L>=0); a full load SHALL perform 72 writes.
REQ-034 row SHALL be 4 bits and byte_cnt SHALL be 3 bits, and neither SHALL wrap within a load.

Reset
REQ-035 rst_n=0 SHALL asynchronously force IDLE, row=0, byte_cnt=0, shift register=0, and all outputs to 0 (mem_address, mem_read, a_wren, b_wren, wr_data, busy, done).
REQ-036 Reset asserted mid-load SHALL abandon the load; the next start SHALL restart from row 0.

Structure
REQ-037 Package mac_fifo_pkg SHALL hold DATA_WIDTH, NUM_ROWS, ROW_BYTES, B_ROW_ADDR=0, A_ROW_BASE=1, and enum loader_state_t.
REQ-038 One sub-module, row_serializer, SHALL be used, providing a 64-bit parallel load, an 8-bit output, a stall input, and a last-byte flag; the FSM and address logic SHALL stay in mem_fifo_loader.

Verification
REQ-039 Memory with L=1 and no waitrequest, row0=0x0807060504030201, start pulse: b_wren SHALL strobe 8 consecutive cycles with wr_data 01..08, done SHALL rise after 90 cycles, and there SHALL be 72 writes total.
REQ-040 mem_waitrequest held high 5 cycles on row 3: mem_address=3 and mem_read=1 SHALL stay stable for those 5 cycles, and exactly one read SHALL be accepted.
REQ-041 a_full[2] high for 4 cycles mid-row 3: writes SHALL pause with no strobe, then resume with the correct next byte, and no byte SHALL be lost or duplicated.
REQ-042 Zero-latency memory (readdatavalid in the accept cycle): WAIT SHALL be skipped, and each row SHALL take 9 cycles.
REQ-043 rst_n low during row 5 SHIFT: all outputs SHALL be 0 immediately; the next start SHALL reissue address 0.
REQ-044 start pulsed while busy: it SHALL be ignored; start in DONE SHALL clear done and begin a new load.

Source files
------------

// File: rtl/mac_fifo_pkg.sv
// Shared sizing constants and FSM state type for the memory-to-FIFO loader.
package mac_fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned NUM_ROWS   = 8;
    localparam int unsigned ROW_BYTES  = 8;
    localparam int unsigned B_ROW_ADDR = 0;
    localparam int unsigned A_ROW_BASE = 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SHIFT,
        DONE
    } loader_state_t;

endpackage

// File: rtl/row_serializer.sv
// Holds one memory row and hands it out one element per accepted write, low element first.
module row_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROW_BYTES  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [DATA_WIDTH*ROW_BYTES-1:0]  load_data,
    input  logic                             shift,
    input  logic                             stall,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             last
);

    localparam int unsigned CNT_W = $clog2(ROW_BYTES);

    logic [DATA_WIDTH*ROW_BYTES-1:0] shift_reg;
    logic [CNT_W-1:0]                byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            byte_cnt  <= '0;
        end else if (shift && !stall) begin
            shift_reg <= shift_reg >> DATA_WIDTH;
            // Counter parks on the last element; the next load clears it.
            if (!last) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
        end
    end

    assign data_out = shift_reg[DATA_WIDTH-1:0];
    assign last     = (byte_cnt == CNT_W'(ROW_BYTES - 1));

endmodule

// File: rtl/mem_fifo_loader.sv
// Reads 9 memory rows (row 0 to the B FIFO, rows 1..8 to A FIFOs) and streams their elements into the FIFOs.
module mem_fifo_loader
    import mac_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mac_fifo_pkg::DATA_WIDTH,
    parameter int unsigned NUM_ROWS   = mac_fifo_pkg::NUM_ROWS,
    parameter int unsigned ROW_BYTES  = mac_fifo_pkg::ROW_BYTES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            mem_address,
    output logic                   mem_read,
    input  logic [63:0]            mem_readdata,
    input  logic                   mem_readdatavalid,
    input  logic                   mem_waitrequest,
    output logic [NUM_ROWS-1:0]    a_wren,
    output logic                   b_wren,
    output logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [NUM_ROWS-1:0]    a_full,
    input  logic                   b_full
);

    localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS);
    localparam logic [3:0] B_ROW    = 4'(B_ROW_ADDR);

    loader_state_t       state;
    logic [3:0]          row;
    logic [3:0]          row_next;
    logic [NUM_ROWS-1:0] a_sel;
    logic                b_sel;
    logic                target_full;
    logic                write_fire;
    logic                ser_load;
    logic                ser_last;

    always_comb begin
        a_sel = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            a_sel[i] = (row == 4'(A_ROW_BASE + i));
        end
    end

    assign b_sel       = (row == B_ROW);
    assign target_full = b_sel ? b_full : |(a_full & a_sel);
    assign write_fire  = (state == SHIFT) && !target_full;
    assign a_wren      = write_fire ? a_sel : '0;
    assign b_wren      = write_fire && b_sel;
    assign row_next    = row + 4'd1;

    // Zero-latency memories return data in the accept cycle, so REQ may load directly.
    assign ser_load = mem_readdatavalid &&
                      ((state == WAIT) || ((state == REQ) && !mem_waitrequest));

    row_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_BYTES  (ROW_BYTES)
    ) u_row_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .load_data (mem_readdata),
        .shift     (state == SHIFT),
        .stall     (target_full),
        .data_out  (wr_data),
        .last      (ser_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= '0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= REQ;
                        row         <= '0;
                        mem_address <= 32'(B_ROW_ADDR);
                        mem_read    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                REQ: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= mem_readdatavalid ? SHIFT : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_readdatavalid) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (write_fire && ser_last) begin
                        if (row == LAST_ROW) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            row         <= row_next;
                            mem_address <= {28'd0, row_next};
                            mem_read    <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fifo_loader.sv
// Scoreboard bench: a small memory model feeds the loader and every FIFO write is checked against queued expectations.
module tb_mem_fifo_loader;

    localparam int unsigned NUM_ROWS = 8;

    typedef struct packed {
        int         row;
        logic [7:0] data;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                busy;
    logic                done;
    logic [31:0]         mem_address;
    logic                mem_read;
    logic [63:0]         mem_readdata;
    logic                mem_readdatavalid;
    logic                mem_waitrequest;
    logic [NUM_ROWS-1:0] a_wren;
    logic                b_wren;
    logic [7:0]          wr_data;
    logic [NUM_ROWS-1:0] a_full;
    logic                b_full;

    logic [63:0] rows [0:15];
    logic        lat1;
    logic        pend;
    logic [3:0]  pend_addr;
    logic [3:0]  rd_addr;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   writes = 0;
    int   accepts = 0;
    int   acc3 = 0;
    int   b_first = 0;
    int   b_last = 0;
    int   b_cnt = 0;
    int   a2_cnt = 0;
    int   a4_cnt = 0;
    logic [NUM_ROWS:0] last_stb;

    mem_fifo_loader #(
        .DATA_WIDTH (8),
        .NUM_ROWS   (NUM_ROWS),
        .ROW_BYTES  (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_waitrequest   (mem_waitrequest),
        .a_wren            (a_wren),
        .b_wren            (b_wren),
        .wr_data           (wr_data),
        .a_full            (a_full),
        .b_full            (b_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: latency 1 (registered response) or 0 (response in the accept cycle).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_addr <= 4'd0;
        end else begin
            pend      <= lat1 && mem_read && !mem_waitrequest;
            pend_addr <= mem_address[3:0];
        end
    end

    assign mem_readdatavalid = lat1 ? pend : (mem_read && !mem_waitrequest);
    assign rd_addr           = lat1 ? pend_addr : mem_address[3:0];
    assign mem_readdata      = mem_readdatavalid ? rows[rd_addr] : 64'd0;

    task automatic step();
        logic [NUM_ROWS:0] stb;
        int   tgt;
        exp_t e;
        #2;
        stb      = {a_wren, b_wren};
        last_stb = stb;
        if (mem_read && !mem_waitrequest) begin
            accepts++;
            if (mem_address == 32'd3) acc3++;
        end
        if (stb != '0) begin
            writes++;
            checks++;
            if ($countones(stb) != 1 || !busy || (a_wren & a_full) != '0 || (b_wren && b_full)) begin
                errors++;
                $display("FAIL strobe_legal: a_wren=%b b_wren=%b busy=%b a_full=%b b_full=%b, required one strobe to a non-full FIFO while busy",
                         a_wren, b_wren, busy, a_full, b_full);
            end
            tgt = 0;
            for (int i = 0; i < NUM_ROWS; i++) if (a_wren[i]) tgt = i + 1;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected write row=%0d data=%02h, required no write", tgt, wr_data);
            end else begin
                e = sbq.pop_front();
                if (tgt !== e.row || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL scoreboard: got row=%0d data=%02h, required row=%0d data=%02h",
                             tgt, wr_data, e.row, e.data);
                end
            end
            if (b_wren) begin
                if (b_cnt == 0) b_first = cyc;
                b_last = cyc;
                b_cnt++;
            end
            if (a_wren[2]) a2_cnt++;
            if (a_wren[4]) a4_cnt++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic push_load();
        for (int r = 0; r < 9; r++) begin
            for (int k = 0; k < 8; k++) begin
                sbq.push_back(exp_t'{row: r, data: rows[r][8*k +: 8]});
            end
        end
    endtask

    task automatic start_load();
        start = 1'b1;
        step();
        start  = 1'b0;
        cyc    = 0;
        b_cnt  = 0;
        a2_cnt = 0;
        a4_cnt = 0;
    endtask

    task automatic wait_done();
        while (!done && cyc < 400) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, mem_read, b_wren} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy,done,mem_read,b_wren=%b, required 0000", {busy, done, mem_read, b_wren});
        end
        checks++;
        if (mem_address !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr: got %h, required 0", mem_address);
        end
        checks++;
        if (a_wren !== '0 || wr_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: a_wren=%b wr_data=%h, required 0", a_wren, wr_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_load();
        int w0, a0;
        lat1 = 1'b1;
        w0 = writes; a0 = accepts;
        push_load();
        start_load();
        wait_done();
        checks++;
        if (!done || cyc != 90) begin
            errors++;
            $display("FAIL full_load_cycles: done=%b after %0d cycles, required done after 90", done, cyc);
        end
        checks++;
        if (b_cnt != 8 || b_first != 2 || b_last != 9) begin
            errors++;
            $display("FAIL b_burst: count=%0d first=%0d last=%0d, required 8 at cycles 2..9", b_cnt, b_first, b_last);
        end
        checks++;
        if (writes - w0 != 72 || accepts - a0 != 9 || sbq.size() != 0) begin
            errors++;
            $display("FAIL full_load_totals: writes=%0d reads=%0d left=%0d, required 72, 9, 0",
                     writes - w0, accepts - a0, sbq.size());
        end
    endtask

    task automatic test_waitrequest();
        int a0, c0;
        a0 = accepts; c0 = acc3;
        push_load();
        start_load();
        while (!(mem_read && mem_address == 32'd3) && cyc < 200) step();
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_read !== 1'b1 || mem_address !== 32'd3) begin
                errors++;
                $display("FAIL wait_stable[%0d]: mem_read=%b addr=%h, required 1 and 3", i, mem_read, mem_address);
            end
            step();
        end
        mem_waitrequest = 1'b0;
        wait_done();
        checks++;
        if (!done || cyc != 95) begin
            errors++;
            $display("FAIL wait_cycles: done=%b after %0d cycles, required done after 95", done, cyc);
        end
        checks++;
        if (acc3 - c0 != 1 || accepts - a0 != 9 || sbq.size() != 0) begin
            errors++;
            $display("FAIL wait_reads: row3 accepts=%0d total=%0d left=%0d, required 1, 9, 0",
                     acc3 - c0, accepts - a0, sbq.size());
        end
    endtask

    task automatic test_stall();
        int w0;
        w0 = writes;
        push_load();
        start_load();
        while (a2_cnt < 3 && cyc < 200) step();
        a_full[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (last_stb !== '0) begin
                errors++;
                $display("FAIL stall_quiet[%0d]: strobes=%b, required 0", i, last_stb);
            end
        end
        a_full[2] = 1'b0;
        wait_done();
        checks++;
        if (!done || cyc != 94) begin
            errors++;
            $display("FAIL stall_cycles: done=%b after %0d cycles, required done after 94", done, cyc);
        end
        checks++;
        if (writes - w0 != 72 || sbq.size() != 0) begin
            errors++;
            $display("FAIL stall_totals: writes=%0d left=%0d, required 72 and 0", writes - w0, sbq.size());
        end
    endtask

    task automatic test_zero_latency();
        lat1 = 1'b0;
        push_load();
        start_load();
        wait_done();
        checks++;
        if (!done || cyc != 81) begin
            errors++;
            $display("FAIL zero_lat_cycles: done=%b after %0d cycles, required done after 81", done, cyc);
        end
        checks++;
        if (b_first != 1 || b_cnt != 8 || sbq.size() != 0) begin
            errors++;
            $display("FAIL zero_lat_b: first=%0d count=%0d left=%0d, required 1, 8, 0", b_first, b_cnt, sbq.size());
        end
        lat1 = 1'b1;
    endtask

    task automatic test_reset_mid();
        push_load();
        start_load();
        while (a4_cnt < 2 && cyc < 200) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_read, b_wren, a_wren, wr_data} !== '0 || mem_address !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b rd=%b addr=%h a=%b b=%b data=%h, required all 0",
                     busy, done, mem_read, mem_address, a_wren, b_wren, wr_data);
        end
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_load();
        start_load();
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'd0) begin
            errors++;
            $display("FAIL restart_addr: mem_read=%b addr=%h, required 1 and 0", mem_read, mem_address);
        end
        wait_done();
        checks++;
        if (!done || cyc != 90 || sbq.size() != 0) begin
            errors++;
            $display("FAIL restart_load: done=%b cycles=%0d left=%0d, required 1, 90, 0", done, cyc, sbq.size());
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = writes;
        push_load();
        start_load();
        repeat (20) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        checks++;
        if (!done || cyc != 90 || writes - w0 != 72) begin
            errors++;
            $display("FAIL start_while_busy: done=%b cycles=%0d writes=%0d, required 1, 90, 72", done, cyc, writes - w0);
        end
        push_load();
        start_load();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || mem_read !== 1'b1 || mem_address !== 32'd0) begin
            errors++;
            $display("FAIL start_in_done: done=%b busy=%b rd=%b addr=%h, required 0, 1, 1, 0",
                     done, busy, mem_read, mem_address);
        end
        wait_done();
        checks++;
        if (!done || cyc != 90 || sbq.size() != 0) begin
            errors++;
            $display("FAIL second_load: done=%b cycles=%0d left=%0d, required 1, 90, 0", done, cyc, sbq.size());
        end
    endtask

    initial begin
        start           = 1'b0;
        mem_waitrequest = 1'b0;
        a_full          = '0;
        b_full          = 1'b0;
        lat1            = 1'b1;
        rst_n           = 1'b0;
        rows[0] = 64'h0807060504030201;
        for (int r = 1; r < 16; r++) rows[r] = {$urandom, $urandom};
        @(negedge clk);

        test_reset();
        test_full_load();
        test_waitrequest();
        test_stall();
        test_zero_latency();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
